multi_timer_bcd: RTL and testbench
==================================

# multi_timer_bcd

Parametrised multi-channel BCD stopwatch/countdown core. Each channel runs independently as an up-counting stopwatch or a down-counting timer, with start/stop, lap freeze, load, clear and expiry detection. All state sits on one clock, and counting advances on an external one-cycle `tick` enable, so no derived clocks are used. It sits between the debounce/one-pulse/button-decode front end, which issues `cmd_*`, and the scan_ctl/ssd display path, which consumes `disp_bcd`.

## Interface
- `CH_W`, default 1: channel-index width; channel count `CH = 2**CH_W`.
- `UPPER_MAX`, default 59: maximum of the upper field (binary value; 23 gives hh:mm).
- `LOWER_MAX`, default 59: maximum of the lower field.

Ports:
- `clk`  in  1: single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `tick`  in  1: one-`clk` count-enable pulse (e.g. 1 Hz strobe).
- `cmd_valid`  in  1: command strobe, one cycle.
- `cmd_op`  in  3: 0 NOP, 1 START, 2 LAP, 3 STOP, 4 CLEAR, 5 LOAD, 6 MODE_UP, 7 MODE_DOWN.
- `cmd_ch`  in  CH_W: target channel.
- `cmd_data`  in  16: LOAD value, BCD {u1,u0,l1,l0}.
- `disp_sel`  in  CH_W: channel shown on `disp_bcd`.
- `disp_bcd`  out  16: displayed BCD value of `disp_sel`.
- `running`  out  CH: per-channel RUN-or-LAP state.
- `done`  out  CH: per-channel DONE state.
- `done_pulse`  out  1: one-cycle pulse when any channel enters DONE.
- `cmd_err`  out  1: one-cycle pulse when a command is rejected.

## Operation
- Per-channel registers: `cnt` (16-bit BCD), `init` (16-bit BCD), `lap` (16-bit BCD), `dir` (0 = up, 1 = down), and an FSM with states IDLE, RUN, LAP, DONE.
- Reset: `cnt`, `init` and `lap` = 0000; `dir` = 0; state IDLE. All outputs are 0 and `disp_bcd` = 0000.
- START:
  - IDLE goes to RUN.
  - DONE reloads `cnt` from `init` and goes to RUN.
  - LAP goes to RUN and releases the freeze.
  - If `dir` = 1 and the start value is 0000, START is rejected with a `cmd_err` pulse.
- LAP: RUN goes to LAP and sets `lap` = `cnt`. Counting continues while in LAP. In any other state LAP is a no-op.
- STOP: RUN or LAP goes to IDLE, and `cnt` holds its value.
- CLEAR: any state goes to IDLE. `cnt` = `init` if `dir` = 1, otherwise 0000.
- LOAD:
  - Accepted only in IDLE or DONE; sets `init` = `cnt` = `cmd_data`, and DONE goes to IDLE.
  - Rejected with a `cmd_err` pulse if any digit is greater than 9, a field exceeds its MAX, or the channel is in RUN/LAP.
- MODE_UP / MODE_DOWN: set `dir`. Accepted only in IDLE; otherwise rejected with a `cmd_err` pulse.
- Counting happens on `tick` in RUN/LAP only.
- Up count:
  - `l0` increments; at 9 it carries into `l1`.
  - When the lower field reaches `LOWER_MAX` it resets to 00 and carries into the upper field.
  - When the count reaches `UPPER_MAX:LOWER_MAX`, it wraps to 0000 and keeps running.
- Down count:
  - Mirror borrow: from 00 the lower field goes to `LOWER_MAX` and borrows from the upper field.
  - The tick that produces 0000 moves the channel to DONE.
- DONE: `cnt` = 0000 and further ticks are ignored. `done_pulse` fires once, one cycle after the entering edge.
- `disp_bcd` = `lap[disp_sel]` in LAP, otherwise `cnt[disp_sel]`.
- An out-of-range `cmd_ch` cannot occur, since `CH = 2**CH_W`.

## Timing
- Commands are sampled on the `clk` edge with `cmd_valid` = 1. State, registers, `running` and `done` update on that edge.
- `disp_bcd` is a combinational mux of registered state. It changes in the same cycle as the register update and immediately on a `disp_sel` change.
- `cmd_err` and `done_pulse` are registered and high for exactly the cycle after the causing edge.
- Simultaneous `tick` and command on the same channel: the command wins and the tick is dropped for that channel only. Other channels still count.
- Tick on the START edge: START only changes state; the first count happens on the next tick.
- Tick on the STOP edge: the tick is dropped, and `cnt` holds the pre-edge value.
- Multiple channels entering DONE on the same edge produce one `done_pulse`.
- `rst` asserted mid-count clears everything asynchronously. The first tick after deassertion has no effect, because all channels are IDLE.

## Configuration
- `TIMER_LAP_EN` defined: the LAP state, `lap` registers and the LAP command are as described above.
- `TIMER_LAP_EN` undefined:
  - No LAP state and no `lap` registers.
  - `cmd_op` = 2 is a NOP with no `cmd_err`.
  - `disp_bcd` is always `cnt[disp_sel]`.
  - `running` is the RUN state only.

## Test plan
- Up count: reset, START ch0, 61 ticks gives ch0 `disp_bcd` = 0101. Preload 5959, START, 1 tick gives 0000 with `running[0]` still 1.
- Down count: MODE_DOWN ch1, LOAD 0002, START, 2 ticks gives `done[1]` = 1, `done_pulse` for one cycle, `disp_bcd` = 0000. Further ticks leave it at 0000. START reloads 0002 and resumes.
- Rejections (each gives one `cmd_err` pulse and no state change):
  - LOAD 0960;
  - LOAD 00A0;
  - LOAD while RUN;
  - MODE_DOWN while RUN;
  - START in down mode with 0000.
- Lap (macro on): START, 5 ticks, LAP, 3 ticks gives `disp_bcd` = 0005. START gives 0008. Macro off: the same sequence shows 0008 with no `cmd_err`.
- Command/tick collision: STOP ch0 together with `tick` holds ch0 `cnt`, while running ch1 increments on the same edge.
- Mid-run reset: `rst` pulse during RUN gives all outputs 0 asynchronously; the next tick leaves `disp_bcd` = 0000.

Source files
------------

// File: rtl/multi_timer_bcd.sv
// multi_timer_bcd: multi-channel BCD stopwatch / countdown core advancing on an external tick enable.
// Optional feature macro: TIMER_LAP_EN (lap freeze state, lap registers and the LAP command).
module multi_timer_bcd #(
   parameter int CH_W      = 1,
   parameter int UPPER_MAX = 59,
   parameter int LOWER_MAX = 59
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 cmd_valid,
   input  logic [2:0]           cmd_op,
   input  logic [CH_W-1:0]      cmd_ch,
   input  logic [15:0]          cmd_data,
   input  logic [CH_W-1:0]      disp_sel,
   output logic [15:0]          disp_bcd,
   output logic [2**CH_W-1:0]   running,
   output logic [2**CH_W-1:0]   done,
   output logic                 done_pulse,
   output logic                 cmd_err
);
   // state  | meaning
   // IDLE   | stopped, cnt held
   // RUN    | counting on tick
   // LAP    | counting on tick, display frozen on lap
   // DONE   | countdown reached 0000, ticks ignored

   localparam int CH = 2**CH_W;

   localparam logic [2:0] OP_START = 3'd1;
   localparam logic [2:0] OP_STOP  = 3'd3;
   localparam logic [2:0] OP_CLEAR = 3'd4;
   localparam logic [2:0] OP_LOAD  = 3'd5;
   localparam logic [2:0] OP_MUP   = 3'd6;
   localparam logic [2:0] OP_MDN   = 3'd7;
`ifdef TIMER_LAP_EN
   localparam logic [2:0] OP_LAP   = 3'd2;
`endif

   localparam logic [7:0] UMAX_BCD = {4'(UPPER_MAX / 10), 4'(UPPER_MAX % 10)};
   localparam logic [7:0] LMAX_BCD = {4'(LOWER_MAX / 10), 4'(LOWER_MAX % 10)};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_DONE} state_t;

   state_t        r_state [CH];
   logic [15:0]   r_cnt   [CH];
   logic [15:0]   r_init  [CH];
`ifdef TIMER_LAP_EN
   logic [15:0]   r_lap   [CH];
`endif
   logic [CH-1:0] r_dir;
   logic          r_cmd_err;
   logic          r_done_pulse;

   logic [15:0]   w_step  [CH];
   logic [CH-1:0] w_hit;
   logic [CH-1:0] w_active;
   logic [CH-1:0] w_done_entry;
   logic [15:0]   w_start_val;
   logic          w_err;

   function automatic logic [7:0] fld_inc(input logic [7:0] f, input logic [7:0] fmax);
      logic [7:0] r;
      if (f == fmax)            r = 8'h00;
      else if (f[3:0] == 4'd9)  r = {f[7:4] + 4'd1, 4'h0};
      else                      r = {f[7:4], f[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] fld_dec(input logic [7:0] f, input logic [7:0] fmax);
      logic [7:0] r;
      if (f == 8'h00)           r = fmax;
      else if (f[3:0] == 4'd0)  r = {f[7:4] - 4'd1, 4'h9};
      else                      r = {f[7:4], f[3:0] - 4'd1};
      return r;
   endfunction

   // Lower field carries/borrows into the upper field only when it wraps.
   function automatic logic [15:0] cnt_step(input logic [15:0] v, input logic down);
      logic [7:0] lo;
      logic [7:0] hi;
      if (down) begin
         lo = fld_dec(v[7:0], LMAX_BCD);
         hi = (v[7:0] == 8'h00) ? fld_dec(v[15:8], UMAX_BCD) : v[15:8];
      end else begin
         lo = fld_inc(v[7:0], LMAX_BCD);
         hi = (v[7:0] == LMAX_BCD) ? fld_inc(v[15:8], UMAX_BCD) : v[15:8];
      end
      return {hi, lo};
   endfunction

   // With all digits valid, BCD ordering equals numeric ordering.
   function automatic logic bcd_ok(input logic [15:0] v);
      return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) &&
             (v[3:0] <= 4'd9) && (v[15:8] <= UMAX_BCD) && (v[7:0] <= LMAX_BCD);
   endfunction

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         w_hit[c]        = cmd_valid && (cmd_ch == CH_W'(c));
         w_active[c]     = (r_state[c] == S_RUN) || (r_state[c] == S_LAP);
         w_step[c]       = cnt_step(r_cnt[c], r_dir[c]);
         w_done_entry[c] = tick && !w_hit[c] && w_active[c] && r_dir[c] &&
                           (w_step[c] == 16'h0000);
      end
   end

   always_comb begin
      w_start_val = (r_state[cmd_ch] == S_DONE) ? r_init[cmd_ch] : r_cnt[cmd_ch];
      w_err       = 1'b0;
      if (cmd_valid) begin
         case (cmd_op)
            OP_START:       w_err = r_dir[cmd_ch] && (w_start_val == 16'h0000);
            OP_LOAD:        w_err = !((r_state[cmd_ch] == S_IDLE) || (r_state[cmd_ch] == S_DONE)) ||
                                    !bcd_ok(cmd_data);
            OP_MUP, OP_MDN: w_err = (r_state[cmd_ch] != S_IDLE);
            default:        w_err = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            r_state[c] <= S_IDLE;
            r_cnt[c]   <= 16'h0000;
            r_init[c]  <= 16'h0000;
`ifdef TIMER_LAP_EN
            r_lap[c]   <= 16'h0000;
`endif
         end
         r_dir        <= '0;
         r_cmd_err    <= 1'b0;
         r_done_pulse <= 1'b0;
      end else begin
         r_cmd_err    <= w_err;
         r_done_pulse <= |w_done_entry;
         for (int c = 0; c < CH; c++) begin
            if (w_hit[c]) begin
               // A command on this channel swallows a coincident tick.
               case (cmd_op)
                  OP_START: begin
                     if (!w_err && (r_state[c] != S_RUN)) begin
                        r_cnt[c]   <= w_start_val;
                        r_state[c] <= S_RUN;
                     end
                  end
`ifdef TIMER_LAP_EN
                  OP_LAP: begin
                     if (r_state[c] == S_RUN) begin
                        r_lap[c]   <= r_cnt[c];
                        r_state[c] <= S_LAP;
                     end
                  end
`endif
                  OP_STOP: begin
                     if (w_active[c]) r_state[c] <= S_IDLE;
                  end
                  OP_CLEAR: begin
                     r_state[c] <= S_IDLE;
                     r_cnt[c]   <= r_dir[c] ? r_init[c] : 16'h0000;
                  end
                  OP_LOAD: begin
                     if (!w_err) begin
                        r_init[c]  <= cmd_data;
                        r_cnt[c]   <= cmd_data;
                        r_state[c] <= S_IDLE;
                     end
                  end
                  OP_MUP: begin
                     if (!w_err) r_dir[c] <= 1'b0;
                  end
                  OP_MDN: begin
                     if (!w_err) r_dir[c] <= 1'b1;
                  end
                  default: ;
               endcase
            end else if (tick && w_active[c]) begin
               r_cnt[c] <= w_step[c];
               if (w_done_entry[c]) r_state[c] <= S_DONE;
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         running[c] = w_active[c];
         done[c]    = (r_state[c] == S_DONE);
      end
   end

`ifdef TIMER_LAP_EN
   assign disp_bcd = (r_state[disp_sel] == S_LAP) ? r_lap[disp_sel] : r_cnt[disp_sel];
`else
   assign disp_bcd = r_cnt[disp_sel];
`endif

   assign cmd_err    = r_cmd_err;
   assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_multi_timer_bcd.sv
// Self-checking bench for multi_timer_bcd: directed test-plan sequences plus randomized
// commands/ticks, checked every cycle against a seconds-based reference model.
module tb_multi_timer_bcd;
   localparam int CH_W = 1;
   localparam int CH   = 2**CH_W;
   localparam int UMAX = 59;
   localparam int LMAX = 59;
   localparam int PER  = (UMAX + 1) * (LMAX + 1);
`ifdef TIMER_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif
   localparam int ST_IDLE = 0, ST_RUN = 1, ST_LAP = 2, ST_DONE = 3;
   localparam logic [2:0] NOP = 0, START = 1, LAP = 2, STOP = 3, CLEAR = 4, LOAD = 5,
                          MUP = 6, MDN = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic            tick;
   logic            cmd_valid;
   logic [2:0]      cmd_op;
   logic [CH_W-1:0] cmd_ch;
   logic [15:0]     cmd_data;
   logic [CH_W-1:0] disp_sel;
   logic [15:0]     disp_bcd;
   logic [CH-1:0]   running;
   logic [CH-1:0]   done;
   logic            done_pulse;
   logic            cmd_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counts held as elapsed units (upper*(LMAX+1)+lower).
   int m_cnt [CH];
   int m_init[CH];
   int m_lap [CH];
   int m_st  [CH];
   bit m_dir [CH];
   bit m_err;
   bit m_dp;

   always #5 clk = ~clk;

   multi_timer_bcd dut (
      .clk(clk), .rst(rst), .tick(tick), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ch(cmd_ch), .cmd_data(cmd_data), .disp_sel(disp_sel), .disp_bcd(disp_bcd),
      .running(running), .done(done), .done_pulse(done_pulse), .cmd_err(cmd_err)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      int u, l;
      u = v / (LMAX + 1);
      l = v % (LMAX + 1);
      return {4'(u / 10), 4'(u % 10), 4'(l / 10), 4'(l % 10)};
   endfunction

   function automatic bit load_ok(input logic [15:0] d, output int val);
      int u, l;
      u = 10 * int'(d[15:12]) + int'(d[11:8]);
      l = 10 * int'(d[7:4]) + int'(d[3:0]);
      val = u * (LMAX + 1) + l;
      return d[15:12] < 10 && d[11:8] < 10 && d[7:4] < 10 && d[3:0] < 10 &&
             u <= UMAX && l <= LMAX;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = 0; m_init[c] = 0; m_lap[c] = 0; m_st[c] = ST_IDLE; m_dir[c] = 0;
      end
      m_err = 0;
      m_dp  = 0;
   endtask

   task automatic model_step(input bit t, input bit v, input logic [2:0] op, input int ch,
                             input logic [15:0] d);
      int sv, val;
      m_err = 0;
      m_dp  = 0;
      for (int c = 0; c < CH; c++) begin
         if (v && ch == c) begin
            case (op)
               START: begin
                  sv = (m_st[c] == ST_DONE) ? m_init[c] : m_cnt[c];
                  if (m_dir[c] && sv == 0) m_err = 1;
                  else if (m_st[c] != ST_RUN) begin m_cnt[c] = sv; m_st[c] = ST_RUN; end
               end
               LAP: if (LAP_EN && m_st[c] == ST_RUN) begin m_st[c] = ST_LAP; m_lap[c] = m_cnt[c]; end
               STOP: if (m_st[c] == ST_RUN || m_st[c] == ST_LAP) m_st[c] = ST_IDLE;
               CLEAR: begin m_st[c] = ST_IDLE; m_cnt[c] = m_dir[c] ? m_init[c] : 0; end
               LOAD: begin
                  if ((m_st[c] == ST_IDLE || m_st[c] == ST_DONE) && load_ok(d, val)) begin
                     m_init[c] = val; m_cnt[c] = val; m_st[c] = ST_IDLE;
                  end else m_err = 1;
               end
               MUP, MDN: begin
                  if (m_st[c] == ST_IDLE) m_dir[c] = (op == MDN);
                  else m_err = 1;
               end
               default: ;
            endcase
         end else if (t && (m_st[c] == ST_RUN || m_st[c] == ST_LAP)) begin
            if (!m_dir[c]) m_cnt[c] = (m_cnt[c] + 1) % PER;
            else begin
               m_cnt[c] = m_cnt[c] - 1;
               if (m_cnt[c] == 0) begin m_st[c] = ST_DONE; m_dp = 1; end
            end
         end
      end
   endtask

   task automatic check_all();
      logic [CH-1:0] e_run, e_done;
      for (int c = 0; c < CH; c++) begin
         e_run[c]  = (m_st[c] == ST_RUN || m_st[c] == ST_LAP);
         e_done[c] = (m_st[c] == ST_DONE);
      end
      check_val("cmd_err", 32'(cmd_err), 32'(m_err));
      check_val("done_pulse", 32'(done_pulse), 32'(m_dp));
      check_val("running", 32'(running), 32'(e_run));
      check_val("done", 32'(done), 32'(e_done));
      for (int c = 0; c < CH; c++) begin
         disp_sel = CH_W'(c);
         #1;
         check_val($sformatf("disp_ch%0d", c), 32'(disp_bcd),
                   32'(to_bcd(m_st[c] == ST_LAP ? m_lap[c] : m_cnt[c])));
      end
   endtask

   task automatic cyc(input bit t, input bit v, input logic [2:0] op, input int ch,
                      input logic [15:0] d);
      tick = t; cmd_valid = v; cmd_op = op; cmd_ch = CH_W'(ch); cmd_data = d;
      @(posedge clk);
      model_step(t, v, op, ch, d);
      #1;
      check_all();
      tick = 0; cmd_valid = 0; cmd_op = NOP;
   endtask

   task automatic cmd(input logic [2:0] op, input int ch, input logic [15:0] d);
      cyc(0, 1, op, ch, d);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, NOP, 0, 16'h0);
   endtask

   task automatic show(input int ch, input string tag, input logic [15:0] exp);
      @(negedge clk);
      disp_sel = CH_W'(ch);
      #1;
      check_val(tag, 32'(disp_bcd), 32'(exp));
   endtask

   bit          r_t, r_v;
   logic [2:0]  r_op;
   int          r_ch;
   logic [15:0] r_d;

   initial begin
      rst = 1; tick = 0; cmd_valid = 0; cmd_op = NOP; cmd_ch = '0; cmd_data = 16'h0;
      disp_sel = '0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst = 0;

      // Up count and wrap
      cmd(START, 0, 0);
      ticks(61);
      show(0, "up_61_ticks", 16'h0101);
      cmd(STOP, 0, 0);
      cmd(LOAD, 0, 16'h5959);
      cmd(START, 0, 0);
      ticks(1);
      show(0, "wrap_5959", 16'h0000);
      check_val("wrap_running", 32'(running[0]), 32'd1);
      cmd(STOP, 0, 0);

      // Down count to DONE, then restart
      cmd(MDN, 1, 0);
      cmd(LOAD, 1, 16'h0002);
      cmd(START, 1, 0);
      ticks(2);
      check_val("down_done1", 32'(done[1]), 32'd1);
      check_val("down_pulse", 32'(done_pulse), 32'd1);
      ticks(3);
      show(1, "done_hold", 16'h0000);
      cmd(START, 1, 0);
      show(1, "restart_reload", 16'h0002);

      // Rejections
      cmd(LOAD, 0, 16'h0960);
      check_val("rej_load_0960", 32'(cmd_err), 32'd1);
      cmd(LOAD, 0, 16'h00A0);
      check_val("rej_load_00A0", 32'(cmd_err), 32'd1);
      cmd(LOAD, 1, 16'h0010);
      check_val("rej_load_run", 32'(cmd_err), 32'd1);
      cmd(MDN, 1, 0);
      check_val("rej_mode_run", 32'(cmd_err), 32'd1);
      cmd(STOP, 1, 0);
      cmd(MDN, 0, 0);
      cmd(START, 0, 0);
      check_val("rej_start_zero", 32'(cmd_err), 32'd1);
      cmd(MUP, 0, 0);

      // Lap freeze
      cmd(CLEAR, 0, 0);
      cmd(START, 0, 0);
      ticks(5);
      cmd(LAP, 0, 0);
      check_val("lap_no_err", 32'(cmd_err), 32'd0);
      ticks(3);
      show(0, "lap_view", LAP_EN ? 16'h0005 : 16'h0008);
      cmd(START, 0, 0);
      show(0, "lap_release", 16'h0008);

      // Command/tick collision
      cmd(MUP, 1, 0);
      cmd(CLEAR, 1, 0);
      cmd(START, 1, 0);
      cyc(1, 1, STOP, 0, 0);
      show(0, "coll_hold_ch0", 16'h0008);
      show(1, "coll_inc_ch1", 16'h0001);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r_t  = ($urandom_range(0, 1) == 1);
         r_v  = ($urandom_range(0, 2) == 0);
         r_op = 3'($urandom_range(0, 7));
         r_ch = $urandom_range(0, CH - 1);
         r_d  = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 8)) : 16'($urandom);
         cyc(r_t, r_v, r_op, r_ch, r_d);
      end

      // Mid-run asynchronous reset
      cmd(MUP, 0, 0);
      cmd(CLEAR, 0, 0);
      cmd(START, 0, 0);
      ticks(3);
      @(negedge clk);
      #2 rst = 1;
      #1;
      model_reset();
      check_val("rst_running", 32'(running), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_cmd_err", 32'(cmd_err), 32'd0);
      check_val("rst_pulse", 32'(done_pulse), 32'd0);
      disp_sel = '0;
      #1;
      check_val("rst_disp", 32'(disp_bcd), 32'd0);
      @(negedge clk);
      rst = 0;
      ticks(1);
      show(0, "post_rst_tick", 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
